// File: rtl/boot_loader_if.sv
// boot_loader_if: ROM read, RAM write and CPU-release signals between the boot loader and the SoC
interface boot_loader_if #(
   parameter int ROM_AW = 8,
   parameter int RAM_AW = 12
);
   logic [ROM_AW-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic [RAM_AW-1:0] ram_addr;
   logic [63:0]       ram_wdata;
   logic              ram_we;
   logic              mem_owner;
   logic              cpu_run;
   logic              busy;
   logic [31:0]       checksum;
   logic              reload;
   modport master (
      input  rom_data, reload,
      output rom_addr, ram_addr, ram_wdata, ram_we, mem_owner, cpu_run, busy, checksum
   );
   modport slave (
      output rom_data, reload,
      input  rom_addr, ram_addr, ram_wdata, ram_we, mem_owner, cpu_run, busy, checksum
   );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: copies the ROM image into RAM at LOAD_BASE, then hands the RAM bus to the core and releases it
module boot_loader #(
   parameter int          ROM_AW    = 8,
   parameter int          RAM_AW    = 12,
   parameter int unsigned LOAD_BASE = 'h800,
   parameter int          LOAD_LEN  = 256
) (
   input logic           clk,
   input logic           rst_n,
   boot_loader_if.master bus
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   localparam logic [ROM_AW-1:0] LAST = ROM_AW'(LOAD_LEN - 1);
   state_t            state_q, state_d;
   logic [ROM_AW-1:0] cnt_q, cnt_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       sum_q, sum_d;
   logic              we_q, own_q, busy_q;
   // Next state, word counter, running checksum and the address registers that follow the new state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      case (state_q)
         IDLE: state_d = RD;
         RD:   state_d = WR;
         WR: begin
            sum_d   = sum_q + bus.rom_data;
            state_d = (cnt_q == LAST) ? DONE : RD;
            cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
         end
         DONE: begin
            state_d = bus.reload ? RD : DONE;
            cnt_d   = bus.reload ? '0 : cnt_q;
            sum_d   = bus.reload ? '0 : sum_q;
         end
      endcase
      rom_addr_d = (state_d == RD) ? cnt_d : rom_addr_q;
      ram_addr_d = (state_d == WR) ? RAM_AW'(LOAD_BASE) + RAM_AW'(cnt_d) : ram_addr_q;
   end
   // State and registered outputs; reset aborts any copy in progress and returns the bus to the loader
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sum_q      <= '0;
         rom_addr_q <= '0;
         ram_addr_q <= '0;
         we_q       <= 1'b0;
         own_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sum_q      <= sum_d;
         rom_addr_q <= rom_addr_d;
         ram_addr_q <= ram_addr_d;
         we_q       <= state_d == WR;
         own_q      <= state_d == DONE;
         busy_q     <= state_d == RD || state_d == WR;
      end
   end
   assign bus.rom_addr  = rom_addr_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = we_q ? {32'b0, bus.rom_data} : '0;
   assign bus.ram_we    = we_q;
   assign bus.mem_owner = own_q;
   assign bus.cpu_run   = own_q;
   assign bus.busy      = busy_q;
   assign bus.checksum  = sum_q;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed scoreboard bench for three loader configurations (len 4, len 1, wrapping base)
module tb_boot_loader;
   logic       clk = 1'b0;
   logic [2:0] rst_n = '0;
   int         checks = 0;
   int         failures = 0;
   logic [31:0] rom [3][256];
   logic [75:0] q [3][$];
   int          wcnt [3];
   logic [31:0] exp_sum [3];
   logic [3:0]  st [3];
   logic [31:0] cs [3];
   logic [7:0]  ra [3];
   logic [11:0] wa [3];
   logic [63:0] wd [3];

   always #5 clk = ~clk;

   boot_loader_if #(.ROM_AW(8), .RAM_AW(12)) ia ();
   boot_loader_if #(.ROM_AW(8), .RAM_AW(12)) ib ();
   boot_loader_if #(.ROM_AW(8), .RAM_AW(12)) ic ();

   boot_loader #(.LOAD_LEN(4)) da (.clk(clk), .rst_n(rst_n[0]), .bus(ia));
   boot_loader #(.LOAD_LEN(1)) db (.clk(clk), .rst_n(rst_n[1]), .bus(ib));
   boot_loader #(.LOAD_BASE('hFFE), .LOAD_LEN(4)) dc (.clk(clk), .rst_n(rst_n[2]), .bus(ic));

   // Registered ROM models: data appears one cycle after the address
   always @(posedge clk) begin
      ia.rom_data <= rom[0][ia.rom_addr];
      ib.rom_data <= rom[1][ib.rom_addr];
      ic.rom_data <= rom[2][ic.rom_addr];
   end

   assign st[0] = {ia.busy, ia.cpu_run, ia.mem_owner, ia.ram_we};
   assign st[1] = {ib.busy, ib.cpu_run, ib.mem_owner, ib.ram_we};
   assign st[2] = {ic.busy, ic.cpu_run, ic.mem_owner, ic.ram_we};
   assign cs[0] = ia.checksum;
   assign cs[1] = ib.checksum;
   assign cs[2] = ic.checksum;
   assign ra[0] = ia.rom_addr;
   assign ra[1] = ib.rom_addr;
   assign ra[2] = ic.rom_addr;
   assign wa[0] = ia.ram_addr;
   assign wa[1] = ib.ram_addr;
   assign wa[2] = ic.ram_addr;
   assign wd[0] = ia.ram_wdata;
   assign wd[1] = ib.ram_wdata;
   assign wd[2] = ic.ram_wdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_reload(input int d, input logic v);
      case (d)
         0: ia.reload = v;
         1: ib.reload = v;
         default: ic.reload = v;
      endcase
   endtask

   task automatic mon(input int d);
      logic [75:0] e;
      chk($sformatf("owner_eq_run%0d", d), st[d][1], st[d][2]);
      chk($sformatf("we_with_owner%0d", d), st[d][0] & st[d][1], 0);
      if (st[d][0]) begin
         wcnt[d]++;
         chk($sformatf("wr_expected%0d", d), q[d].size() != 0, 1);
         if (q[d].size() != 0) begin
            e = q[d].pop_front();
            chk($sformatf("wr_addr%0d", d), wa[d], e[75:64]);
            chk($sformatf("wr_data%0d", d), wd[d], e[63:0]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) mon(d);
   endtask

   task automatic start_expect(input int d, input int len, input logic [11:0] base);
      exp_sum[d] = '0;
      wcnt[d] = 0;
      for (int i = 0; i < len; i++) begin
         q[d].push_back({base + 12'(i), 32'b0, rom[d][i]});
         exp_sum[d] += rom[d][i];
      end
   endtask

   task automatic check_copy(input int d, input int len, input logic hold);
      logic done;
      for (int e = 1; e <= 2 * len + 1; e++) begin
         tick();
         if (e == 1) begin
            set_reload(d, hold);
            chk($sformatf("start_rom_addr%0d", d), ra[d], 0);
            chk($sformatf("start_sum%0d", d), cs[d], 0);
         end
         done = (e == 2 * len + 1);
         chk($sformatf("status%0d_e%0d", d, e), st[d], {e <= 2 * len, done, done, e % 2 == 0});
      end
      chk($sformatf("checksum%0d", d), cs[d], exp_sum[d]);
      chk($sformatf("writes%0d", d), wcnt[d], len);
      chk($sformatf("queue_empty%0d", d), q[d].size(), 0);
   endtask

   task automatic chk_zero(input int d);
      chk($sformatf("rst_status%0d", d), st[d], 0);
      chk($sformatf("rst_rom_addr%0d", d), ra[d], 0);
      chk($sformatf("rst_ram_addr%0d", d), wa[d], 0);
      chk($sformatf("rst_wdata%0d", d), wd[d], 0);
      chk($sformatf("rst_sum%0d", d), cs[d], 0);
   endtask

   initial begin
      ia.reload = 1'b0;
      ib.reload = 1'b0;
      ic.reload = 1'b0;
      foreach (rom[d, i]) rom[d][i] = '0;
      rom[0][0] = 32'h910003E0;
      rom[0][1] = 32'h910007E1;
      rom[0][2] = 32'h8B000022;
      rom[0][3] = 32'h8B1F0020;
      rom[1][0] = 32'hDEADBEEF;
      rom[2][0] = 32'h11111111;
      rom[2][1] = 32'h22222222;
      rom[2][2] = 32'h33333333;
      rom[2][3] = 32'h44444444;
      repeat (3) tick();
      for (int d = 0; d < 3; d++) chk_zero(d);
      start_expect(0, 4, 12'h800);
      rst_n[0] = 1'b1;
      check_copy(0, 4, 1'b0);
      chk("sum_known", cs[0], 32'h381F0C03);
      rom[0][0] = 32'h91001FE2;
      start_expect(0, 4, 12'h800);
      set_reload(0, 1'b1);
      check_copy(0, 4, 1'b0);
      start_expect(0, 4, 12'h800);
      set_reload(0, 1'b1);
      tick();
      set_reload(0, 1'b0);
      repeat (3) tick();
      chk("second_wr_active", st[0], 4'b1001);
      rst_n[0] = 1'b0;
      #1;
      chk_zero(0);
      q[0].delete();
      repeat (3) tick();
      chk("no_write_in_reset", wcnt[0], 2);
      start_expect(0, 4, 12'h800);
      rst_n[0] = 1'b1;
      check_copy(0, 4, 1'b0);
      start_expect(0, 4, 12'h800);
      set_reload(0, 1'b1);
      check_copy(0, 4, 1'b1);
      start_expect(0, 4, 12'h800);
      check_copy(0, 4, 1'b0);
      for (int i = 0; i < 4; i++) rom[0][i] = 32'hFFFFFFFF;
      start_expect(0, 4, 12'h800);
      set_reload(0, 1'b1);
      check_copy(0, 4, 1'b0);
      chk("sum_wrap", cs[0], 32'hFFFFFFFC);
      start_expect(1, 1, 12'h800);
      rst_n[1] = 1'b1;
      check_copy(1, 1, 1'b0);
      start_expect(2, 4, 12'hFFE);
      rst_n[2] = 1'b1;
      check_copy(2, 4, 1'b0);
      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
